// File: rtl/imem_stream_loader.sv
// imem_stream_loader: packs a little-endian byte stream into INST_W words, writes them to the export port and gates the core until done.
// Optional readback verification of every written word is built when IMEM_VERIFY_EN is defined.
module imem_stream_loader #(
  parameter int INST_W = 32,
  parameter int INST_A = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [INST_A-1:0] exp_address,
  output logic [INST_W-1:0] exp_data,
  output logic              exp_MW,
  output logic              exp_MR,
  input  logic [INST_W-1:0] exp_out
);
  localparam int BPW = INST_W / 8;
  localparam int BW = BPW > 1 ? $clog2(BPW) : 1;
  localparam int DEPTH = 1 << INST_A;
  typedef enum logic [2:0] {
    HDR0, HDR1, DATA, WRITE,
`ifdef IMEM_VERIFY_EN
    VERIFY,
`endif
    DONE, ERR
  } state_t;
  state_t state;
  logic [15:0] n, cnt, wnext;
  logic [INST_A:0] wcnt;
  logic [BW-1:0] bcnt;
  assign cnt = {rx_data, n[7:0]};
  assign wnext = 16'(wcnt) + 16'd1;
  assign rx_ready = state == HDR0 || state == HDR1 || state == DATA;
  assign done = state == DONE;
  assign cpu_enable = done;
  assign err = state == ERR;
  assign exp_MW = state == WRITE;
`ifdef IMEM_VERIFY_EN
  logic ph;
  logic [INST_W-1:0] shadow [DEPTH];
  assign busy = rx_ready || state == WRITE || state == VERIFY;
  assign exp_MR = state == VERIFY && !ph;
  always_ff @(posedge clk)
    if (state == WRITE) shadow[exp_address] <= exp_data;
`else
  logic unused_out;
  assign unused_out = ^exp_out;
  assign busy = rx_ready || state == WRITE;
  assign exp_MR = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HDR0;
      n <= '0;
      wcnt <= '0;
      bcnt <= '0;
      exp_address <= '0;
      exp_data <= '0;
`ifdef IMEM_VERIFY_EN
      ph <= 1'b0;
`endif
    end else begin
      case (state)
        HDR0: if (rx_valid) begin
          n[7:0] <= rx_data;
          state <= HDR1;
        end
        HDR1: if (rx_valid) begin
          n[15:8] <= rx_data;
          state <= cnt == 16'd0 ? DONE : 32'(cnt) > DEPTH ? ERR : DATA;
        end
        DATA: if (rx_valid) begin
          exp_data[{bcnt, 3'b000} +: 8] <= rx_data;
          bcnt <= bcnt == BW'(BPW - 1) ? '0 : bcnt + 1'b1;
          if (bcnt == BW'(BPW - 1)) state <= WRITE;
        end
        WRITE: begin
          wcnt <= wcnt + 1'b1;
          // the address only advances when another word follows, so it never passes DEPTH-1
          if (wnext == n) begin
`ifdef IMEM_VERIFY_EN
            state <= VERIFY;
            exp_address <= '0;
            ph <= 1'b0;
`else
            state <= DONE;
`endif
          end else begin
            state <= DATA;
            exp_address <= exp_address + 1'b1;
          end
        end
`ifdef IMEM_VERIFY_EN
        VERIFY: begin
          ph <= !ph;
          // read data for the address strobed last cycle is on exp_out now
          if (ph) begin
            if (exp_out != shadow[exp_address]) state <= ERR;
            else if (16'(exp_address) == n - 16'd1) state <= DONE;
            else exp_address <= exp_address + 1'b1;
          end
        end
`endif
        default: if (reload) begin
          state <= HDR0;
          n <= '0;
          wcnt <= '0;
          bcnt <= '0;
          exp_address <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader: scoreboard bench; expected writes are queued as bytes are sent and popped on each exp_MW.
module tb_imem_stream_loader;
  logic clk = 0, reset = 1, rx_valid = 0, reload = 0;
  logic [7:0] rx_data = 0;
  logic rx_ready, cpu_enable, busy, done, err, exp_MW, exp_MR;
  logic [7:0] exp_address;
  logic [31:0] exp_data, exp_out = 0;
  logic [31:0] mem [256];
  logic [39:0] q [$];
  logic corrupt = 0;
  int n_cmp = 0, n_bad = 0, n_mw = 0, n_mr = 0;
  logic [7:0] last_addr = 0;

  imem_stream_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .cpu_enable(cpu_enable), .busy(busy), .done(done), .err(err),
    .exp_address(exp_address), .exp_data(exp_data), .exp_MW(exp_MW), .exp_MR(exp_MR),
    .exp_out(exp_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_MW) begin
      n_mw++;
      last_addr = exp_address;
      mem[exp_address] = exp_data;
      chk("mw_mr_excl", exp_MR, 0);
      if (q.size() == 0) chk("mw_unexpected", 1, 0);
      else begin
        logic [39:0] e;
        e = q.pop_front();
        chk("wr_addr", exp_address, e[39:32]);
        chk("wr_data", exp_data, e[31:0]);
      end
    end
    if (exp_MR) n_mr++;
  end

  always @(posedge clk)
    if (exp_MR) exp_out <= mem[exp_address] ^ ((corrupt && exp_address == 8'd1) ? 32'h1 : 32'h0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit jitter);
    bit acc;
    int t;
    if (jitter) repeat ($urandom_range(0, 2)) tick();
    rx_data = b;
    rx_valid = 1;
    t = 0;
    do begin
      acc = rx_ready;
      tick();
      t++;
    end while (!acc && t < 1000);
    if (!acc) chk("byte_accept_timeout", 0, 1);
    rx_valid = 0;
  endtask

  task automatic send_word(input logic [7:0] a, input logic [31:0] w, input bit jitter);
    q.push_back({a, w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], jitter);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!done && !err && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) chk("end_timeout", 0, 1);
  endtask

  task automatic do_reload();
    reload = 1;
    tick();
    reload = 0;
  endtask

  initial begin
    int mw0;
    tick();
    tick();
    reset = 0;
    chk("rst_busy", busy, 1);
    chk("rst_ready", rx_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cpu", cpu_enable, 0);
    chk("rst_mw", exp_MW, 0);
    chk("rst_mr", exp_MR, 0);
    chk("rst_addr", exp_address, 0);
    chk("rst_data", exp_data, 0);
    // 1: two-word load
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(8'd0, 32'h12345678, 0);
    chk("wr_latency", exp_MW, 1);
    send_word(8'd1, 32'hDEADBEEF, 0);
    wait_end();
    chk("t1_done", done, 1);
    chk("t1_cpu", cpu_enable, 1);
    chk("t1_nmw", n_mw, 2);
    chk("t1_q", q.size(), 0);
    // 2: zero-length load
    do_reload();
    chk("rl_busy", busy, 1);
    chk("rl_done", done, 0);
    chk("rl_cpu", cpu_enable, 0);
    mw0 = n_mw;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t2_done", done, 1);
    chk("t2_err", err, 0);
    chk("t2_nmw", n_mw, mw0);
    // 3: oversize count
    do_reload();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("t3_err", err, 1);
    chk("t3_cpu", cpu_enable, 0);
    chk("t3_ready", rx_ready, 0);
    do_reload();
    chk("t3_rl_err", err, 0);
    chk("t3_rl_ready", rx_ready, 1);
    chk("t3_rl_busy", busy, 1);
    // 4: full-capacity load with gaps
    mw0 = n_mw;
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    for (int i = 0; i < 256; i++) send_word(i[7:0], $urandom, 1);
    wait_end();
    chk("t4_done", done, 1);
    chk("t4_nmw", n_mw - mw0, 256);
    chk("t4_last_addr", last_addr, 8'hFF);
    chk("t4_q", q.size(), 0);
    // 5: reset mid-load
    do_reload();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(8'd0, 32'hCAFEF00D, 0);
    send_byte(8'hAA, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("t5_ready", rx_ready, 1);
    chk("t5_busy", busy, 1);
    chk("t5_done", done, 0);
    chk("t5_q", q.size(), 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(8'd0, 32'h0BADC0DE, 0);
    wait_end();
    chk("t5_fresh_done", done, 1);
    chk("t5_fresh_q", q.size(), 0);
`ifdef IMEM_VERIFY_EN
    // 6: readback verify, clean then corrupted
    for (int c = 0; c < 2; c++) begin
      corrupt = c[0];
      do_reload();
      n_mr = 0;
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_word(8'd0, 32'h11112222, 0);
      send_word(8'd1, 32'h33334444, 0);
      wait_end();
      chk("t6_nmr", n_mr, 2);
      chk("t6_done", done, !c[0]);
      chk("t6_err", err, c[0]);
      chk("t6_cpu", cpu_enable, !c[0]);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
